// File: rtl/alu_muldiv_control_if.sv
// ---------------------------------------------------------------------------
// alu_muldiv_control_if
//
// Purpose: bundles the decode inputs, the HI/LO engine issue signals and all
// results of alu_muldiv_control into a single bus. The EX-stage controller
// drives through the master modport and the decoder/engine sits on the slave
// modport.
//
// Signals (master view):
//   ALUOp     out 4      [2:0]=010 selects R-type, [3]=1 forces unsigned
//   Funct     out 6      instruction funct field
//   start     out 1      one-cycle issue strobe for HI/LO-class funct
//   A, B      out WIDTH  rs / rt operands
//   ALUConf   in  5      main-ALU configuration (combinational)
//   Sign      in  1      main-ALU signedness (combinational)
//   busy      in  1      multiply/divide in progress
//   done      in  1      one-cycle pulse when HI/LO are updated
//   HI, LO    in  WIDTH  HI/LO registers
//   mf_result in  WIDTH  HI for mfhi, LO for mflo, else 0
// ---------------------------------------------------------------------------
interface alu_muldiv_control_if #(
  parameter int WIDTH = 32
) ();

  logic [3:0]       ALUOp;
  logic [5:0]       Funct;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [4:0]       ALUConf;
  logic             Sign;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic [WIDTH-1:0] mf_result;

  modport master (
    output ALUOp, Funct, start, A, B,
    input  ALUConf, Sign, busy, done, HI, LO, mf_result
  );

  modport slave (
    input  ALUOp, Funct, start, A, B,
    output ALUConf, Sign, busy, done, HI, LO, mf_result
  );

endinterface

// File: rtl/alu_muldiv_control.sv
// ---------------------------------------------------------------------------
// alu_muldiv_control
//
// Purpose: ALU control decoder for the EX stage plus an iterative
// multiply/divide engine with HI/LO registers. The decoder maps ALUOp/Funct
// onto the main-ALU configuration and signedness. The engine executes
// mult/multu/div/divu (shift-add / restoring, one bit per cycle, WIDTH+1
// edges in total) and mthi/mtlo, and exposes HI/LO to mfhi/mflo.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-low reset
//   bus    slave modport of alu_muldiv_control_if (same WIDTH as here)
// ---------------------------------------------------------------------------
module alu_muldiv_control #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_muldiv_control_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  // Main-ALU configuration encodings
  localparam logic [4:0] CONF_AND = 5'b00000;
  localparam logic [4:0] CONF_OR  = 5'b00001;
  localparam logic [4:0] CONF_ADD = 5'b00010;
  localparam logic [4:0] CONF_SUB = 5'b00110;
  localparam logic [4:0] CONF_SLT = 5'b00111;
  localparam logic [4:0] CONF_NOR = 5'b01000;
  localparam logic [4:0] CONF_XOR = 5'b01001;
  localparam logic [4:0] CONF_SLL = 5'b01010;
  localparam logic [4:0] CONF_SRL = 5'b10000;
  localparam logic [4:0] CONF_SRA = 5'b10001;

  // R-type funct codes
  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2a;
  localparam logic [5:0] F_SLTU  = 6'h2b;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               isDiv_q;
  logic               negRes_q;
  logic               negRem_q;
  logic               divZero_q;
  logic               busy_q;
  logic               done_q;

  logic               rType;
  logic [4:0]         aluConf;
  logic               sign;

  assign rType = (bus.ALUOp[2:0] == 3'b010);

  // Main-ALU decode. Non-R ops take their signedness from ALUOp[3]; R-type
  // ops are signed except the explicitly unsigned variants. Anything not in
  // the table, including the HI/LO class, falls back to add.
  always_comb begin
    aluConf = CONF_ADD;
    sign    = ~bus.ALUOp[3];
    case (bus.ALUOp[2:0])
      3'b000: aluConf = CONF_ADD;
      3'b001: aluConf = CONF_SUB;
      3'b011: aluConf = CONF_AND;
      3'b100: aluConf = CONF_SLT;
      3'b010: begin
        sign = 1'b1;
        case (bus.Funct)
          F_ADDU:  sign = 1'b0;
          F_SUB:   aluConf = CONF_SUB;
          F_SUBU: begin
            aluConf = CONF_SUB;
            sign    = 1'b0;
          end
          F_AND:   aluConf = CONF_AND;
          F_OR:    aluConf = CONF_OR;
          F_XOR:   aluConf = CONF_XOR;
          F_NOR:   aluConf = CONF_NOR;
          F_SLT:   aluConf = CONF_SLT;
          F_SLTU: begin
            aluConf = CONF_SLT;
            sign    = 1'b0;
          end
          F_SLL:   aluConf = CONF_SLL;
          F_SRL:   aluConf = CONF_SRL;
          F_SRA:   aluConf = CONF_SRA;
          F_MULTU: sign = 1'b0;
          F_DIVU:  sign = 1'b0;
          default: aluConf = CONF_ADD;
        endcase
      end
      default: aluConf = CONF_ADD;
    endcase
  end

  logic             issue;
  logic             opSigned;
  logic             aNeg;
  logic             bNeg;
  logic [WIDTH-1:0] aMag;
  logic [WIDTH-1:0] bMag;

  // Operand magnitudes. The most negative value negates to itself, which read
  // as unsigned is exactly 2^(WIDTH-1), so no extra bit is needed.
  assign issue    = (state_q == IDLE) && bus.start && rType;
  assign opSigned = (bus.Funct == F_MULT) || (bus.Funct == F_DIV);
  assign aNeg     = opSigned && bus.A[WIDTH-1];
  assign bNeg     = opSigned && bus.B[WIDTH-1];
  assign aMag     = aNeg ? -bus.A : bus.A;
  assign bMag     = bNeg ? -bus.B : bus.B;

  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulStep;
  logic [WIDTH:0]     divTrial;
  logic [2*WIDTH-1:0] divStep;

  // Multiply step: acc holds {partial product, remaining multiplier bits};
  // add the multiplicand into the top half when the current multiplier bit
  // is set, then shift the whole accumulator right by one with the carry.
  assign mulSum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
  assign mulStep = acc_q[0] ? {mulSum, acc_q[WIDTH-1:1]}
                            : {1'b0, acc_q[2*WIDTH-1:1]};

  // Restoring divide step: acc holds {remainder, dividend/quotient bits}.
  // Shift the next dividend bit into the remainder and try the subtraction;
  // a borrow keeps the shifted remainder and shifts in a 0 quotient bit.
  assign divTrial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
  assign divStep  = divTrial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                    : {divTrial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quotFix;
  logic [WIDTH-1:0]   remFix;

  // Sign correction. A zero divisor keeps the all-ones quotient unnegated;
  // the remainder then equals the dividend magnitude, so re-applying the
  // dividend sign reproduces A unchanged.
  assign prodFix = negRes_q ? -acc_q : acc_q;
  assign quotFix = (negRes_q && !divZero_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign remFix  = negRem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  // Engine FSM. IDLE accepts issues (moves complete at once), MUL/DIV run
  // WIDTH iterations, FIX writes HI/LO and pulses done while returning to
  // IDLE, so a new start can be accepted during the done cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      isDiv_q   <= 1'b0;
      negRes_q  <= 1'b0;
      negRem_q  <= 1'b0;
      divZero_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (issue) begin
            case (bus.Funct)
              F_MTHI: hi_q <= bus.A;
              F_MTLO: lo_q <= bus.A;
              F_MULT, F_MULTU: begin
                state_q   <= MUL;
                acc_q     <= {{WIDTH{1'b0}}, bMag};
                opnd_q    <= aMag;
                isDiv_q   <= 1'b0;
                negRes_q  <= aNeg ^ bNeg;
                negRem_q  <= aNeg;
                divZero_q <= 1'b0;
                cnt_q     <= '0;
                busy_q    <= 1'b1;
              end
              F_DIV, F_DIVU: begin
                state_q   <= DIV;
                acc_q     <= {{WIDTH{1'b0}}, aMag};
                opnd_q    <= bMag;
                isDiv_q   <= 1'b1;
                negRes_q  <= aNeg ^ bNeg;
                negRem_q  <= aNeg;
                divZero_q <= (bus.B == '0);
                cnt_q     <= '0;
                busy_q    <= 1'b1;
              end
              default: state_q <= IDLE;
            endcase
          end
        end
        MUL, DIV: begin
          acc_q <= (state_q == DIV) ? divStep : mulStep;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            cnt_q   <= '0;
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        FIX: begin
          if (isDiv_q) begin
            hi_q <= remFix;
            lo_q <= quotFix;
          end else begin
            hi_q <= prodFix[2*WIDTH-1:WIDTH];
            lo_q <= prodFix[WIDTH-1:0];
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // mfhi/mflo read only the architectural registers; the controller stalls
  // on busy, so an in-flight result is never forwarded here.
  always_comb begin
    bus.mf_result = '0;
    if (rType && (bus.Funct == F_MFHI)) begin
      bus.mf_result = hi_q;
    end else if (rType && (bus.Funct == F_MFLO)) begin
      bus.mf_result = lo_q;
    end
  end

  assign bus.ALUConf = aluConf;
  assign bus.Sign    = sign;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.HI      = hi_q;
  assign bus.LO      = lo_q;

endmodule

// File: tb/tb_alu_muldiv_control.sv
// ---------------------------------------------------------------------------
// tb_alu_muldiv_control
//
// Purpose: self-checking bench for alu_muldiv_control. A WIDTH=32 instance
// covers decode, the multiply/divide corner cases, moves, busy handling and
// reset; WIDTH=8 and WIDTH=16 instances run mixed mult/div traffic against a
// behavioural reference model.
// ---------------------------------------------------------------------------
module tb_alu_muldiv_control;

  localparam int W = 32;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;

  logic clk = 1'b0;
  logic reset;
  logic subGo = 1'b0;

  always #5 clk = ~clk;

  alu_muldiv_control_if #(.WIDTH(W)) ifc ();
  alu_muldiv_control #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(ifc));

  int checks = 0;
  int errors = 0;

  typedef struct {
    string        name;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  typedef struct {
    string        name;
    logic [5:0]   f;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } opVec_t;

  typedef struct {
    logic [3:0] op;
    logic [5:0] f;
    logic [4:0] conf;
    logic       sg;
  } decVec_t;

  exp_t sbq[$];
  exp_t monE;

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse retires the oldest expected result.
  always @(negedge clk) begin
    if (reset === 1'b1 && ifc.done === 1'b1) begin
      if (sbq.size() == 0) begin
        checkOutput("unexpected done", {63'd0, ifc.done}, 64'd0);
      end else begin
        monE = sbq.pop_front();
        checkOutput({monE.name, " HI"}, 64'(ifc.HI), 64'(monE.hi));
        checkOutput({monE.name, " LO"}, 64'(ifc.LO), 64'(monE.lo));
      end
    end
  end

  // Drive one R-type issue for a single cycle; returns on the next negedge.
  task automatic applyStimulus(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    ifc.ALUOp = 4'b0010;
    ifc.Funct = f;
    ifc.A     = a;
    ifc.B     = b;
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
  endtask

  // Wait (bounded) for done, counting the cycles busy was seen high.
  task automatic waitDone(input string name, output int busyCycles);
    int guard;
    guard      = 0;
    busyCycles = 0;
    while (ifc.done !== 1'b1 && guard < 200) begin
      if (ifc.busy === 1'b1) busyCycles++;
      @(negedge clk);
      guard++;
    end
    checkOutput({name, " done seen"}, {63'd0, ifc.done}, 64'd1);
  endtask

  task automatic runOp(input string name, input logic [5:0] f, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] hi, input logic [W-1:0] lo);
    int bc;
    sbq.push_back('{name, hi, lo});
    applyStimulus(f, a, b);
    waitDone(name, bc);
    checkOutput({name, " busy cycles"}, 64'(bc), 64'(W + 1));
  endtask

  function automatic void refDecode(input logic [3:0] op, input logic [5:0] f,
                                    output logic [4:0] conf, output logic sg);
    conf = 5'b00010;
    sg   = ~op[3];
    case (op[2:0])
      3'b001: conf = 5'b00110;
      3'b011: conf = 5'b00000;
      3'b100: conf = 5'b00111;
      3'b010: begin
        sg = 1'b1;
        case (f)
          6'h21: sg = 1'b0;
          6'h22: conf = 5'b00110;
          6'h23: begin conf = 5'b00110; sg = 1'b0; end
          6'h24: conf = 5'b00000;
          6'h25: conf = 5'b00001;
          6'h26: conf = 5'b01001;
          6'h27: conf = 5'b01000;
          6'h2a: conf = 5'b00111;
          6'h2b: begin conf = 5'b00111; sg = 1'b0; end
          6'h00: conf = 5'b01010;
          6'h02: conf = 5'b10000;
          6'h03: conf = 5'b10001;
          6'h19: sg = 1'b0;
          6'h1b: sg = 1'b0;
          default: conf = 5'b00010;
        endcase
      end
      default: conf = 5'b00010;
    endcase
  endfunction

  // Narrow-width instances checked against a behavioural model.
  for (genvar gi = 0; gi < 2; gi++) begin : gSub
    localparam int SW = (gi == 0) ? 8 : 16;

    alu_muldiv_control_if #(.WIDTH(SW)) sIf ();
    alu_muldiv_control #(.WIDTH(SW)) sDut (.clk(clk), .reset(reset), .bus(sIf));

    logic finished = 1'b0;

    task automatic subModel(input logic [5:0] f, input logic [SW-1:0] a, input logic [SW-1:0] b,
                            output logic [SW-1:0] hi, output logic [SW-1:0] lo);
      longint sa, sb, ua, ub, r;
      sa = $signed(a);
      sb = $signed(b);
      ua = longint'(a);
      ub = longint'(b);
      r  = 0;
      hi = '0;
      lo = '0;
      case (f)
        F_MULT, F_MULTU: begin
          r  = (f == F_MULT) ? sa * sb : ua * ub;
          hi = r[2*SW-1:SW];
          lo = r[SW-1:0];
        end
        default: begin
          if (b == '0) begin
            hi = a;
            lo = '1;
          end else if (f == F_DIV) begin
            r  = sa % sb;
            hi = r[SW-1:0];
            r  = sa / sb;
            lo = r[SW-1:0];
          end else begin
            r  = ua % ub;
            hi = r[SW-1:0];
            r  = ua / ub;
            lo = r[SW-1:0];
          end
        end
      endcase
    endtask

    initial begin
      logic [SW-1:0] a, b, eh, el;
      logic [5:0]    f;
      int            guard;
      sIf.ALUOp = 4'b0010;
      sIf.Funct = 6'h00;
      sIf.start = 1'b0;
      sIf.A     = '0;
      sIf.B     = '0;
      wait (subGo === 1'b1);
      @(negedge clk);
      for (int k = 0; k < 16; k++) begin
        f = F_MULT + 6'(k % 4);
        a = SW'($urandom);
        b = SW'($urandom);
        if (k == 6) begin
          a = {1'b1, {(SW-1){1'b0}}};
          b = '1;
        end
        if (k == 8 || k == 9) begin
          a = {1'b1, {(SW-1){1'b0}}};
          b = {1'b1, {(SW-1){1'b0}}};
        end
        if (k == 10 || k == 11) b = '0;
        subModel(f, a, b, eh, el);
        sIf.Funct = f;
        sIf.A     = a;
        sIf.B     = b;
        sIf.start = 1'b1;
        @(negedge clk);
        sIf.start = 1'b0;
        guard = 0;
        while (sIf.done !== 1'b1 && guard < 100) begin
          @(negedge clk);
          guard++;
        end
        checkOutput($sformatf("w%0d op%0d done", SW, k), {63'd0, sIf.done}, 64'd1);
        checkOutput($sformatf("w%0d op%0d f=%0h a=%0h b=%0h HI", SW, k, f, a, b), 64'(sIf.HI), 64'(eh));
        checkOutput($sformatf("w%0d op%0d f=%0h a=%0h b=%0h LO", SW, k, f, a, b), 64'(sIf.LO), 64'(el));
      end
      finished = 1'b1;
    end
  end

  opVec_t  opTab[$];
  decVec_t decTab[$];

  initial begin
    int         bc;
    int         guard;
    logic [4:0] eConf;
    logic       eSg;

    // Corner-case multiply/divide vectors with hand-derived results
    opTab.push_back('{"mult -3*7",     F_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB});
    opTab.push_back('{"multu fffffffd*7", F_MULTU, 32'hFFFFFFFD, 32'h00000007, 32'h00000006, 32'hFFFFFFEB});
    opTab.push_back('{"div -7/2",      F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD});
    opTab.push_back('{"divu 8000000/3", F_DIVU, 32'h80000000, 32'h00000003, 32'h00000002, 32'h2AAAAAAA});
    opTab.push_back('{"div by zero",   F_DIV,   32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF});
    opTab.push_back('{"div overflow",  F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000});
    opTab.push_back('{"mult min*min",  F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000});
    opTab.push_back('{"multu max*max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
    opTab.push_back('{"div 100/-7",    F_DIV,   32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2});
    opTab.push_back('{"divu 7/16",     F_DIVU,  32'h00000007, 32'h00000010, 32'h00000007, 32'h00000000});
    opTab.push_back('{"div -100/0",    F_DIV,   32'hFFFFFF9C, 32'h00000000, 32'hFFFFFF9C, 32'hFFFFFFFF});
    opTab.push_back('{"mult x*0",      F_MULT,  32'h00012345, 32'h00000000, 32'h00000000, 32'h00000000});

    // Decode vectors
    decTab.push_back('{4'b0000, 6'h00, 5'b00010, 1'b1});
    decTab.push_back('{4'b1000, 6'h00, 5'b00010, 1'b0});
    decTab.push_back('{4'b0001, 6'h22, 5'b00110, 1'b1});
    decTab.push_back('{4'b0011, 6'h00, 5'b00000, 1'b1});
    decTab.push_back('{4'b0100, 6'h00, 5'b00111, 1'b1});
    decTab.push_back('{4'b1100, 6'h00, 5'b00111, 1'b0});
    decTab.push_back('{4'b0111, 6'h24, 5'b00010, 1'b1});
    decTab.push_back('{4'b0010, 6'h20, 5'b00010, 1'b1});
    decTab.push_back('{4'b0010, 6'h21, 5'b00010, 1'b0});
    decTab.push_back('{4'b0010, 6'h23, 5'b00110, 1'b0});
    decTab.push_back('{4'b0010, 6'h25, 5'b00001, 1'b1});
    decTab.push_back('{4'b0010, 6'h26, 5'b01001, 1'b1});
    decTab.push_back('{4'b0010, 6'h27, 5'b01000, 1'b1});
    decTab.push_back('{4'b0010, 6'h2b, 5'b00111, 1'b0});
    decTab.push_back('{4'b0010, 6'h03, 5'b10001, 1'b1});
    decTab.push_back('{4'b0010, 6'h02, 5'b10000, 1'b1});
    decTab.push_back('{4'b1010, 6'h00, 5'b01010, 1'b1});
    decTab.push_back('{4'b0010, 6'h19, 5'b00010, 1'b0});
    decTab.push_back('{4'b0010, 6'h10, 5'b00010, 1'b1});

    ifc.ALUOp = 4'b0000;
    ifc.Funct = 6'h00;
    ifc.start = 1'b0;
    ifc.A     = '0;
    ifc.B     = '0;
    reset     = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset HI",   64'(ifc.HI), 64'd0);
    checkOutput("reset LO",   64'(ifc.LO), 64'd0);
    checkOutput("reset busy", {63'd0, ifc.busy}, 64'd0);
    checkOutput("reset done", {63'd0, ifc.done}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] decode table");
    foreach (decTab[i]) begin
      ifc.ALUOp = decTab[i].op;
      ifc.Funct = decTab[i].f;
      #1;
      checkOutput($sformatf("decode op=%b f=%0h conf", decTab[i].op, decTab[i].f), 64'(ifc.ALUConf), 64'(decTab[i].conf));
      checkOutput($sformatf("decode op=%b f=%0h sign", decTab[i].op, decTab[i].f), {63'd0, ifc.Sign}, {63'd0, decTab[i].sg});
    end

    $display("[TB] decode sweep");
    for (int op = 0; op < 16; op++) begin
      for (int f = 0; f < 64; f++) begin
        ifc.ALUOp = 4'(op);
        ifc.Funct = 6'(f);
        #1;
        refDecode(4'(op), 6'(f), eConf, eSg);
        checkOutput($sformatf("sweep op=%0d f=%0h", op, f), {58'd0, ifc.ALUConf, ifc.Sign}, {58'd0, eConf, eSg});
      end
    end
    @(negedge clk);

    $display("[TB] multiply/divide table");
    foreach (opTab[i]) begin
      runOp(opTab[i].name, opTab[i].f, opTab[i].a, opTab[i].b, opTab[i].hi, opTab[i].lo);
    end
    @(negedge clk);
    checkOutput("done single cycle", {63'd0, ifc.done}, 64'd0);

    $display("[TB] mthi while busy");
    sbq.push_back('{"mult 3*4", 32'd0, 32'd12});
    applyStimulus(F_MULT, 32'd3, 32'd4);
    ifc.Funct = F_MTHI;
    ifc.A     = 32'h0000DEAD;
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    waitDone("mult 3*4", bc);
    checkOutput("mthi ignored while busy", 64'(ifc.HI), 64'd0);

    $display("[TB] moves");
    applyStimulus(F_MTHI, 32'h0000BEEF, 32'd0);
    checkOutput("mthi HI",      64'(ifc.HI), 64'h0000BEEF);
    checkOutput("mthi no done", {63'd0, ifc.done}, 64'd0);
    checkOutput("mthi no busy", {63'd0, ifc.busy}, 64'd0);
    applyStimulus(F_MTLO, 32'h00001234, 32'd0);
    checkOutput("mtlo LO", 64'(ifc.LO), 64'h00001234);
    checkOutput("mtlo keeps HI", 64'(ifc.HI), 64'h0000BEEF);
    ifc.Funct = F_MFLO;
    #1;
    checkOutput("mflo result", 64'(ifc.mf_result), 64'h00001234);
    ifc.Funct = F_MFHI;
    #1;
    checkOutput("mfhi result", 64'(ifc.mf_result), 64'h0000BEEF);
    ifc.Funct = 6'h20;
    #1;
    checkOutput("mf other funct", 64'(ifc.mf_result), 64'd0);
    @(negedge clk);

    $display("[TB] back-to-back issue");
    runOp("b2b mult 6*7", F_MULT, 32'd6, 32'd7, 32'd0, 32'd42);
    runOp("b2b divu 100/9", F_DIVU, 32'd100, 32'd9, 32'd1, 32'd11);
    @(negedge clk);

    $display("[TB] reset mid-operation");
    applyStimulus(F_MULT, 32'd5, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("abort HI",   64'(ifc.HI), 64'd0);
    checkOutput("abort LO",   64'(ifc.LO), 64'd0);
    checkOutput("abort busy", {63'd0, ifc.busy}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("post-abort idle", {62'd0, ifc.busy, ifc.done}, 64'd0);
    runOp("mult 5*7 after reset", F_MULT, 32'd5, 32'd7, 32'd0, 32'd35);
    @(negedge clk);

    $display("[TB] narrow widths");
    subGo = 1'b1;
    guard = 0;
    while (!(gSub[0].finished && gSub[1].finished) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("narrow widths finished", {62'd0, gSub[1].finished, gSub[0].finished}, 64'd3);
    checkOutput("scoreboard drained", 64'(sbq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_control.md
Name: alu_muldiv_control

Overview:
Parametrised successor to the multi-cycle CPU's ALU control decoder. It keeps the combinational ALUOp/Funct → ALUConf/Sign decode and adds a WIDTH-generic iterative multiply/divide engine with HI/LO registers. The engine covers mult/multu/div/divu/mfhi/mflo/mthi/mtlo. It sits beside the main ALU in the EX stage, and the controller stalls on busy.

Parameters:
WIDTH  32  operand, HI and LO width (≥4)
CNT_W  $clog2(WIDTH)+1  iteration counter width (derived; not overridden)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
ALUOp  in  4  [2:0]=3'b010 selects R-type; [3]=1 forces unsigned for non-R ops
Funct  in  6  instruction funct field
start  in  1  one-cycle issue strobe for HI/LO-class funct
A  in  WIDTH  rs operand
B  in  WIDTH  rt operand
ALUConf  out  5  main-ALU config (combinational)
Sign  out  1  main-ALU signedness (combinational)
busy  out  1  mul/div in progress
done  out  1  one-cycle pulse when HI/LO are updated
HI  out  WIDTH  HI register
LO  out  WIDTH  LO register
mf_result  out  WIDTH  HI for mfhi, LO for mflo, else 0 (combinational)

Behaviour:
- Reset (reset=0, async): state=IDLE, HI=0, LO=0, busy=0, done=0, counter=0. Reset mid-operation aborts the operation and leaves no partial HI/LO result.
- Decode, combinational, unchanged encodings: and 00000, or 00001, add 00010, sub 00110, slt 00111, nor 01000, xor 01001, sll 01010, srl 10000, sra 10001.
  - ALUOp[2:0]: 000→add, 001→sub, 011→and, 100→slt, 010→by Funct, others→add.
  - Sign=~ALUOp[3] for non-R ops. For R-type, Sign=0 for addu/subu/sltu/multu/divu, else 1.
  - Unlisted R funct, including the HI/LO class, → add.
- Funct codes: mult 0x18, multu 0x19, div 0x1a, divu 0x1b, mfhi 0x10, mthi 0x11, mflo 0x12, mtlo 0x13.
- Issue: accepted only when state=IDLE, start=1 and ALUOp[2:0]=010.
  - mthi: HI<=A at that edge. mtlo: LO<=A at that edge. State stays IDLE, no done pulse.
  - mult/multu/div/divu: latch operands and signedness at edge E0, go to MUL or DIV, busy=1.
  - start while busy is ignored, including mthi/mtlo. Other funct with start has no effect.
- Signed operations work on magnitudes. MSB set → two's-complement negate; the negated most-negative value is held as unsigned 2^(WIDTH-1).
- MUL: shift-add, one multiplier bit per cycle, WIDTH cycles (E1..EW), into a 2·WIDTH accumulator.
- DIV: restoring, one quotient bit per cycle, WIDTH cycles.
- FIX, edge E(W+1): apply sign correction.
  - Product negated if operand signs differ.
  - Quotient negated if signs differ. Remainder takes the dividend's sign.
  - At the same edge: HI<=product[2W-1:W] or remainder, LO<=product[W-1:0] or quotient, done=1, busy=0, state=IDLE.
- done is high exactly one cycle (E(W+1)→E(W+2)). busy is high E0→E(W+1). Total latency is WIDTH+1 edges after issue.
- A new start is accepted in the cycle done is high.
- Divide by zero: no trap. LO=all ones; HI=dividend A, original sign, unmodified. Same latency.
- Overflow case div(-2^(W-1), -1): LO=-2^(W-1), HI=0, produced by wrap, no special path.
- HI/LO hold their values between operations.
- mf_result reads HI/LO register contents only, never bypassing a result still in flight. The controller must stall on busy.

Test Plan:
- Reset mid-operation: assert reset low at cycle 10 of a mult with A=5, B=7 → HI=LO=0, busy=0 immediately, and the next op runs normally.
- Signed mult, WIDTH=32: mult A=0xFFFFFFFD (-3), B=7 → busy for 33 cycles, done pulse, HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then multu with the same operands → HI=0x00000006, LO=0xFFFFFFEB.
- Signed div: div A=-7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=0x80000000, B=3 → LO=0x2AAAAAAA, HI=0x00000002.
- Divide by zero and overflow: div A=0x12345678, B=0 → LO=0xFFFFFFFF, HI=0x12345678. div A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- Busy and move behaviour: start mthi A=0xDEAD while busy → ignored. Start mthi A=0xBEEF in IDLE → HI=0xBEEF the next cycle, no done. mflo → mf_result=LO. Back-to-back start in the done cycle → accepted.
- Decode sweep: every ALUOp/Funct pair → ALUConf/Sign per the table, e.g. ALUOp=4'b1100 → slt, Sign=0; R sltu → 00111, Sign=0. Rerun the mult/div tests at WIDTH=8 and 16 with a reference model.
